// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit controller.
package uart_pkg;
    localparam int DIV_W = 16;
    localparam logic [DIV_W-1:0] DEFAULT_DIV = 16'd434;
    typedef enum logic [2:0] {IDLE, SYNC, START, DATA, PARITY, STOP} state_e;
    function automatic logic parity_of(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction
    // A zero divisor would make the generator wrap at 65536, so it is treated as 1.
    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] div);
        return (div == '0) ? {{(DIV_W-1){1'b0}}, 1'b1} : div;
    endfunction
endpackage

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit sequencer and owner of the baud generator divisor.
// Defining UART_TX_PARITY_EN adds the parity_odd input and a parity bit after the data.
module uart_tx_ctrl #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter logic [uart_pkg::DIV_W-1:0] DEFAULT_DIV = uart_pkg::DEFAULT_DIV
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [uart_pkg::DIV_W-1:0] cfg_divisor,
    input  logic                       cfg_load,
    output logic [uart_pkg::DIV_W-1:0] baud_rate,
    input  logic                       next_bit,
    input  logic [DATA_BITS-1:0]       tx_data,
    input  logic                       tx_valid,
`ifdef UART_TX_PARITY_EN
    input  logic                       parity_odd,
`endif
    output logic                       tx_ready,
    output logic                       txd,
    output logic                       busy
);
    import uart_pkg::*;

    state_e               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]           cnt_q, cnt_d;
    logic                 txd_q, txd_d;
    logic [DIV_W-1:0]     div_q, div_d, pend_div_q, pend_div_d;
    logic                 pend_q, pend_d;
    logic                 accept, last_data, last_stop, end_bit;

    assign accept    = tx_valid & (state_q == IDLE);
    assign last_data = cnt_q == 3'(DATA_BITS - 1);
    assign last_stop = cnt_q == 3'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
    localparam state_e AFTER_DATA = PARITY;
    logic par_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) par_q <= 1'b0;
        else if (accept) par_q <= parity_of(8'(tx_data), parity_odd);
    end
    assign end_bit = par_q;
`else
    localparam state_e AFTER_DATA = STOP;
    assign end_bit = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            txd_q      <= 1'b1;
            div_q      <= DEFAULT_DIV;
            pend_q     <= 1'b0;
            pend_div_q <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            txd_q      <= txd_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            pend_div_q <= pend_div_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? SYNC : IDLE;
            SYNC:    state_d = next_bit ? START : SYNC;
            START:   state_d = next_bit ? DATA : START;
            DATA:    state_d = (next_bit && last_data) ? AFTER_DATA : DATA;
            PARITY:  state_d = next_bit ? STOP : PARITY;
            STOP:    state_d = (next_bit && last_stop) ? IDLE : STOP;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        txd_d      = txd_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        pend_d     = pend_q;
        pend_div_d = pend_div_q;
        if (state_q == IDLE) begin
            txd_d = 1'b1;
            if (accept) shift_d = tx_data;
            if (cfg_load) div_d = clamp_div(cfg_divisor);
        end else begin
            if (next_bit) begin
                case (state_q)
                    SYNC:   txd_d = 1'b0;
                    START: begin
                        txd_d = shift_q[0];
                        cnt_d = '0;
                    end
                    DATA: begin
                        shift_d = shift_q >> 1;
                        txd_d   = last_data ? end_bit : shift_q[1];
                        cnt_d   = last_data ? 3'd0 : cnt_q + 3'd1;
                    end
                    PARITY: txd_d = 1'b1;
                    default: begin
                        txd_d = 1'b1;
                        cnt_d = cnt_q + 3'd1;
                    end
                endcase
            end
            if (cfg_load) begin
                pend_d     = 1'b1;
                pend_div_d = cfg_divisor;
            end
            // A load in the final stop cycle still wins over the older pending value.
            if (state_d == IDLE) begin
                pend_d = 1'b0;
                if (cfg_load | pend_q) div_d = clamp_div(cfg_load ? cfg_divisor : pend_div_q);
            end
        end
    end

    assign tx_ready  = state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign txd       = txd_q;
    assign baud_rate = div_q;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: randomized bench for uart_tx_ctrl against a frame-level bit-queue model.
module tb_uart_tx_ctrl;
    localparam int DB = 8;
    localparam int SB = 1;
    localparam int LIMIT = 5000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   cfg_divisor = '0;
    logic          cfg_load = 1'b0;
    logic [15:0]   baud_rate;
    logic          next_bit;
    logic [DB-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready, txd, busy;
`ifdef UART_TX_PARITY_EN
    logic          parity_odd = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    uart_tx_ctrl #(.DATA_BITS(DB), .STOP_BITS(SB), .DEFAULT_DIV(16'd434)) dut (
        .clk(clk), .rst(rst), .cfg_divisor(cfg_divisor), .cfg_load(cfg_load),
        .baud_rate(baud_rate), .next_bit(next_bit), .tx_data(tx_data), .tx_valid(tx_valid),
`ifdef UART_TX_PARITY_EN
        .parity_odd(parity_odd),
`endif
        .tx_ready(tx_ready), .txd(txd), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Free-running baud generator fed by the divisor the controller drives.
    logic [15:0] gen_cnt;
    assign next_bit = gen_cnt >= baud_rate - 16'd1;
    always @(posedge clk or posedge rst) begin
        if (rst) gen_cnt <= '0;
        else gen_cnt <= next_bit ? 16'd0 : gen_cnt + 16'd1;
    end

    function automatic logic [15:0] clampf(input logic [15:0] d);
        return (d == 0) ? 16'd1 : d;
    endfunction

    // Reference: a frame is a queue of line levels, one popped per tick; an empty queue on a tick ends the frame.
    bit          q[$];
    bit          m_txd, m_busy, m_pv;
    logic [15:0] m_div, m_pdiv;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_txd = 1'b1;
            m_busy = 1'b0;
            m_pv = 1'b0;
            m_div = 16'd434;
        end else if (!m_busy) begin
            if (cfg_load) m_div = clampf(cfg_divisor);
            if (tx_valid) begin
                m_busy = 1'b1;
                q.push_back(1'b0);
                for (int i = 0; i < DB; i++) q.push_back(tx_data[i]);
`ifdef UART_TX_PARITY_EN
                q.push_back((^tx_data) ^ parity_odd);
`endif
                for (int i = 0; i < SB; i++) q.push_back(1'b1);
            end
        end else begin
            if (cfg_load) begin
                m_pdiv = cfg_divisor;
                m_pv = 1'b1;
            end
            if (next_bit) begin
                if (q.size() == 0) begin
                    m_busy = 1'b0;
                    if (m_pv) m_div = clampf(m_pdiv);
                    m_pv = 1'b0;
                end else m_txd = q.pop_front();
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("txd", txd, m_txd);
            chk("tx_ready", tx_ready, !m_busy);
            chk("busy", busy, m_busy);
            chk("baud_rate", baud_rate, m_div);
        end
    end

    task automatic pulse_cfg(input logic [15:0] v);
        cfg_divisor = v;
        cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input bit hold);
        int n = 0;
        tx_data = d;
        tx_valid = 1'b1;
`ifdef UART_TX_PARITY_EN
        parity_odd = 1'($urandom_range(0, 1));
`endif
        while (!tx_ready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", n < LIMIT, 1);
        @(negedge clk);
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!tx_ready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", n < LIMIT, 1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_txd", txd, 1);
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_baud", baud_rate, 434);
        rst = 1'b0;
        @(negedge clk);
        pulse_cfg(16'd4);
        chk("cfg_idle", baud_rate, 4);
        send(8'hA5, 1'b0);
        repeat (20) @(negedge clk);
        pulse_cfg(16'd8);
        chk("cfg_busy_hold", baud_rate, 4);
        wait_idle();
        chk("cfg_applied", baud_rate, 8);
        send(8'h3C, 1'b0);
        wait_idle();
        pulse_cfg(16'd0);
        chk("zero_clamp", baud_rate, 1);
        send(8'h01, 1'b0);
        wait_idle();
        pulse_cfg(16'd3);
        send(8'h55, 1'b1);
        send(8'h0F, 1'b0);
        wait_idle();
        cfg_divisor = 16'd2;
        cfg_load = 1'b1;
        send(8'hC3, 1'b0);
        cfg_load = 1'b0;
        chk("cfg_with_accept", baud_rate, 2);
        wait_idle();
        for (int k = 0; k < 20; k++) begin
            if ($urandom_range(0, 1) == 1) pulse_cfg(16'($urandom_range(0, 5)));
            send(8'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(0, 30)) @(negedge clk);
                pulse_cfg(16'($urandom_range(0, 5)));
            end
            tx_valid = 1'b0;
            wait_idle();
        end
        pulse_cfg(16'd4);
        send(8'hFF, 1'b0);
        repeat (4 * 5) @(negedge clk);
        pulse_cfg(16'd9);
        rst = 1'b1;
        #1;
        chk("mid_rst_txd", txd, 1);
        chk("mid_rst_ready", tx_ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_baud", baud_rate, 434);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("no_pending_after_rst", baud_rate, 434);
        chk("ready_after_rst", tx_ready, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Transmit sequencer and configuration master for the UART baud-rate generator.
- Owns the generator's 16-bit divisor (baud_rate) and consumes its one-cycle next_bit tick.
- Accepts bytes on a valid/ready handshake and serialises each byte onto txd as: start bit, data bits LSB first, optional parity, stop bits.
- Sits between the host-side TX FIFO/CPU interface and the pin.

Parameters:
- DATA_BITS, 8, data bits per frame (5..8).
- STOP_BITS, 1, stop bits per frame (1 or 2).
- DEFAULT_DIV, 16'd434, divisor driven after reset (50 MHz / 115200).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- cfg_divisor  input  16  new divisor value.
- cfg_load  input  1  one-cycle strobe; request to load cfg_divisor.
- baud_rate  output  16  divisor to the baud generator (registered).
- next_bit  input  1  one-cycle tick from the baud generator, once per bit period.
- tx_data  input  DATA_BITS  byte to send.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  controller can accept a byte.
- txd  output  1  serial line, idle high (registered).
- busy  output  1  frame in progress (state != IDLE).

Behaviour:
- Reset values: txd=1, tx_ready=1, busy=0, baud_rate=DEFAULT_DIV, state=IDLE, pending config cleared.
- Registers: all state registers asynchronous reset, posedge clk.
- Divisor semantics: the generator ticks every baud_rate cycles.
  - cfg_divisor=0 is clamped to 1 when applied; the generator would otherwise wrap at 65536.
  - Divisor 1 means next_bit is high every cycle.
- Config load:
  - cfg_load in IDLE: baud_rate updates on the next clock edge.
  - cfg_load while busy: value is latched as pending and applied on the cycle the FSM returns to IDLE.
  - A later cfg_load overwrites the pending value.
  - cfg_load and acceptance in the same IDLE cycle: the new divisor applies and the frame starts using it.
- Handshake:
  - tx_ready = (state==IDLE).
  - Transfer happens when tx_valid & tx_ready on a clock edge.
  - tx_data is latched into a shift register.
  - tx_valid without tx_ready is held by the producer; no drop, no overwrite.
- FSM states: IDLE -> SYNC -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: txd=1. On accept, go to SYNC. A next_bit in the accept cycle is ignored.
  - SYNC: txd=1. Waits for the first next_bit to align to the free-running generator. On next_bit, go to START and set txd=0.
  - START: on next_bit, go to DATA. txd=data[0]; bit counter = 0.
  - DATA:
    - On next_bit, if counter < DATA_BITS-1: shift, txd = next bit, counter+1.
    - On next_bit at the last bit: go to PARITY (if enabled) or STOP; txd = parity or 1.
  - PARITY: on next_bit, go to STOP; txd=1.
  - STOP: counts STOP_BITS ticks with txd=1. On the final tick, go to IDLE; tx_ready rises the same edge.
- Timing:
  - Every txd change occurs on the clock edge at which next_bit is sampled high, so txd changes one cycle after the tick is asserted.
  - Latency from accept to the start bit is 1..baud_rate+1 cycles.
  - Each bit lasts exactly baud_rate cycles.
- Back-to-back frames: a byte offered while tx_valid is held is accepted in the first IDLE cycle. That frame re-enters SYNC, so there is at least one tick of idle-high between frames.
- Ticks are ignored in IDLE. The bit counter is 3 bits; no wrap beyond DATA_BITS-1.
- Reset mid-frame: txd returns to 1 immediately (asynchronous), the frame is abandoned, and the pending config is discarded.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds input parity_odd (1 bit, sampled at accept).
  - Adds the PARITY state, driving XOR(data) ^ parity_odd for one bit period.
- Undefined: the PARITY state, the port and the XOR logic are absent; DATA goes straight to STOP.

Decomposition:
- Package uart_pkg holds:
  - state enum (IDLE, SYNC, START, DATA, PARITY, STOP);
  - DEFAULT_DIV;
  - divisor width constant (16);
  - parity function.
- No sub-module. The shift register and counters are inline; the baud generator is instantiated beside this block at the top level, not inside it.

Test Plan:
- Reset check: rst pulse -> txd=1, tx_ready=1, busy=0, baud_rate=434.
- Single frame: cfg_load 16'd4; send 8'hA5 -> txd sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; tx_ready high after stop.
- Busy config: cfg_load 16'd8 mid-frame -> baud_rate stays 4 until IDLE, then 8; next frame bits are 8 cycles.
- Zero divisor: cfg_divisor=0 -> baud_rate=1; send 8'h01 -> 10 bit periods of 1 cycle each.
- Back-to-back: tx_valid held with 8'h55 then 8'h0F -> two correct frames, idle-high gap of at least 1 bit, no byte lost.
- Reset mid-DATA: assert rst at bit 3 -> txd=1 asynchronously; tx_ready=1 after release; no residual pending divisor.
